uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one UART byte transmitter among N requesters using round-robin arbitration.
- Each grant sequences one transmitter transaction: a one-cycle start strobe with the byte, then wait for busy to rise, then wait for busy to fall, then an optional inter-byte gap.
- Sits between button/counter logic (send-char sources) and the UART TX serializer inside the UART wrapper.
- Flags a transmitter that never acknowledges a start strobe.

Parameters:
- N, 4, number of requesters (2..8).
- W, 8, data width per requester.
- G, 2, idle gap in clock cycles inserted after each completed byte (0 = back-to-back).
- T, 16, start timeout in cycles: maximum wait for i_tx_busy after o_tx_start (T >= 2).

Ports:
- i_clk  input  1  system clock, rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_req  input  N  per-requester send request; held high with data stable until the matching o_ack.
- i_data  input  N*W  requester k data at bits [k*W +: W].
- o_ack  output  N  one-hot, one-cycle pulse: byte of requester k accepted.
- o_tx_start  output  1  one-cycle start strobe to the transmitter.
- o_tx_data  output  W  byte to the transmitter; valid while o_tx_start = 1, held until the next grant.
- i_tx_busy  input  1  transmitter busy (serializing).
- o_grant  output  clog2(N)  index of the current/last granted requester.
- o_busy  output  1  high in every state except IDLE (LED drive).
- o_err  output  1  one-cycle pulse on start timeout.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - All outputs 0.
  - FSM = IDLE.
  - RR pointer = N-1, so requester 0 has first priority.
  - Counters cleared.
- Reset mid-transaction: abandon immediately. No ack, no err. The transmitter is not told anything.
- States: IDLE, START, WAIT_BUSY, WAIT_DONE, GAP. All outputs are registered.
- IDLE:
  - When |i_req = 1 and i_tx_busy = 0, choose winner w = first asserted index searching ptr+1, ptr+2, … modulo N.
  - At that edge:
    - go to START;
    - load o_tx_data = i_data[w];
    - set o_grant = w and ptr = w;
    - assert o_tx_start = 1 and o_ack[w] = 1.
  - Latency: request sampled at edge k gives start/ack high during cycle k..k+1.
- IDLE with i_tx_busy = 1 (transmitter owned elsewhere or still finishing): no grant.
- START: lasts exactly one cycle. Next edge clears o_tx_start/o_ack and goes to WAIT_BUSY with the timeout counter = 0.
- WAIT_BUSY:
  - i_tx_busy = 1 → go to WAIT_DONE.
  - Otherwise increment the counter; when it reaches T-1 with busy still 0 → pulse o_err for one cycle and go to IDLE (no gap).
  - Busy rising on the same edge the counter reaches T-1: busy wins, no error.
- WAIT_DONE: i_tx_busy = 0 → go to GAP if G > 0, else IDLE. No timeout in this state.
- GAP: count G cycles, then go to IDLE. Requests arriving during GAP are held by the requester and arbitrated in IDLE.
- Requests:
  - A request dropped before its ack is simply not considered.
  - i_req changes outside IDLE have no effect.
  - Data is sampled only at the grant edge.
- Throughput with G = 0 and busy falling at edge j: the next grant can occur at edge j+1, because IDLE needs one cycle.
- The pointer advances only on a grant. A timeout does not revert the pointer.

Test Plan:
- Single request: i_req = 4'b0010, data1 = 8'h41, busy rises 2 cycles after start and lasts 10 cycles.
  - Required: o_ack[1] and o_tx_start pulse together 1 cycle after the request.
  - Required: o_tx_data = 8'h41, o_grant = 1.
  - Required: o_busy is high until G = 2 cycles after busy falls.
- All four requesting simultaneously, each holding until acked, bytes 8'h30..8'h33.
  - Required: grants in order 0,1,2,3.
  - Required: exactly one ack per requester.
  - Required: o_tx_data sequence 30,31,32,33.
- Fairness: requesters 0 and 2 hold i_req permanently for 6 transactions.
  - Required: grants alternate 0,2,0,2,0,2.
  - Required: requester 1 is never acked.
- Timeout: T = 16, transmitter model never raises busy.
  - Required: o_err pulses exactly 16 cycles after o_tx_start.
  - Required: FSM returns to IDLE and the next request is granted normally.
- Busy blocking and boundary: hold i_tx_busy = 1 in IDLE with a pending request.
  - Required: no grant until busy drops; grant on the following edge.
  - Required: busy rising on the T-1 edge raises no o_err.
- Reset mid-operation: assert i_rst_n = 0 during WAIT_DONE.
  - Required: all outputs go to 0 asynchronously.
  - Required: after release, requester 0 wins a simultaneous 0/3 request.
  - Repeat with G = 0 and check back-to-back grants spaced by one IDLE cycle.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter among N send-char sources.
// Each grant drives one start strobe, tracks the transmitter's busy handshake and then inserts an idle gap.
module uart_tx_arbiter #(
  parameter int N = 4,
  parameter int W = 8,
  parameter int G = 2,
  parameter int T = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [N-1:0]           i_req,
  input  logic [N*W-1:0]         i_data,
  output logic [N-1:0]           o_ack,
  output logic                   o_tx_start,
  output logic [W-1:0]           o_tx_data,
  input  logic                   i_tx_busy,
  output logic [$clog2(N)-1:0]   o_grant,
  output logic                   o_busy,
  output logic                   o_err
);

  localparam int GW   = $clog2(N);
  localparam int CMAX = (T > G) ? T : G;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    GAP       = 3'd4
  } state_t;

  state_t        state_r;
  logic [GW-1:0] ptr_r;
  logic [CW-1:0] cnt_r;
  logic [GW-1:0] idx_s;
  logic [GW-1:0] win_s;
  logic          found_s;
  logic [W-1:0]  win_data_s;

  // Pick the first requester after the last winner, wrapping modulo N
  always_comb begin
    found_s = 1'b0;
    win_s   = '0;
    idx_s   = '0;
    for (int i = 1; i <= N; i++) begin
      idx_s   = GW'((int'(ptr_r) + i) % N);
      win_s   = (!found_s && i_req[idx_s]) ? idx_s : win_s;
      found_s = found_s | i_req[idx_s];
    end
  end

  assign win_data_s = i_data[int'(win_s)*W +: W];

  // Transaction sequencer; every output is loaded here so all of them are registered
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r    <= IDLE;
      ptr_r      <= GW'(N - 1);
      cnt_r      <= '0;
      o_ack      <= '0;
      o_tx_start <= 1'b0;
      o_tx_data  <= '0;
      o_grant    <= '0;
      o_busy     <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;
      o_ack      <= '0;
      o_err      <= 1'b0;
      case (state_r)
        IDLE: begin
          // A busy transmitter may still be owned by someone else: hold off granting
          if (found_s && !i_tx_busy) begin
            state_r    <= START;
            o_tx_data  <= win_data_s;
            o_grant    <= win_s;
            ptr_r      <= win_s;
            o_tx_start <= 1'b1;
            o_ack      <= {{(N-1){1'b0}}, 1'b1} << win_s;
            o_busy     <= 1'b1;
          end
        end
        START: begin
          state_r <= WAIT_BUSY;
          cnt_r   <= '0;
        end
        WAIT_BUSY: begin
          if (i_tx_busy) begin
            state_r <= WAIT_DONE;
          end else if (cnt_r == CW'(T - 2)) begin
            state_r <= IDLE;
            o_err   <= 1'b1;
            o_busy  <= 1'b0;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!i_tx_busy) begin
            if (G > 0) begin
              state_r <= GAP;
              cnt_r   <= '0;
            end else begin
              state_r <= IDLE;
              o_busy  <= 1'b0;
            end
          end
        end
        GAP: begin
          if (cnt_r == CW'(G - 1)) begin
            state_r <= IDLE;
            o_busy  <= 1'b0;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: one instance with a 2-cycle gap, one back-to-back instance.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req, ack, req_z, ack_z;
  logic [31:0] data, data_z;
  logic        tx_start, tx_busy, busy, err;
  logic        tx_start_z, tx_busy_z, busy_z, err_z;
  logic [7:0]  tx_data, tx_data_z;
  logic [1:0]  grant, grant_z;

  int checks = 0;
  int errors = 0;
  int ack_cnt [4] = '{0, 0, 0, 0};
  int base [4];
  logic early, seen;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N(4), .W(8), .G(2), .T(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_data(data), .o_ack(ack),
    .o_tx_start(tx_start), .o_tx_data(tx_data), .i_tx_busy(tx_busy),
    .o_grant(grant), .o_busy(busy), .o_err(err)
  );

  uart_tx_arbiter #(.N(4), .W(8), .G(0), .T(16)) dut_z (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req_z), .i_data(data_z), .o_ack(ack_z),
    .o_tx_start(tx_start_z), .o_tx_data(tx_data_z), .i_tx_busy(tx_busy_z),
    .o_grant(grant_z), .o_busy(busy_z), .o_err(err_z)
  );

  // Per-requester ack counter for the gap instance
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ack[i] === 1'b1) ack_cnt[i] = ack_cnt[i] + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input int budget);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("start_seen", {31'b0, ok}, 32'd1);
  endtask

  // Transmitter model: busy rises d cycles after the start strobe and lasts len cycles
  task automatic serve(input int d, input int len);
    repeat (d - 1) @(negedge clk);
    tx_busy = 1'b1;
    repeat (len) @(negedge clk);
    tx_busy = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic snap();
    for (int i = 0; i < 4; i++) base[i] = ack_cnt[i];
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; req = '0; data = '0; tx_busy = 1'b0;
    req_z = '0; data_z = '0; tx_busy_z = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ack", ack, 32'h0);
    chk("rst_start", tx_start, 32'h0);
    chk("rst_data", tx_data, 32'h0);
    chk("rst_grant", grant, 32'h0);
    chk("rst_busy", busy, 32'h0);
    chk("rst_err", err, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 32'h0);

    // Single request from requester 1
    data = 32'h0000_4100; req = 4'b0010;
    @(negedge clk);
    chk("t1_ack", ack, 32'h2);
    chk("t1_start", tx_start, 32'h1);
    chk("t1_data", tx_data, 32'h41);
    chk("t1_grant", grant, 32'h1);
    chk("t1_busy", busy, 32'h1);
    req = '0;
    @(negedge clk);
    chk("t1_start_pulse", tx_start, 32'h0);
    chk("t1_ack_pulse", ack, 32'h0);
    tx_busy = 1'b1;
    repeat (10) @(negedge clk);
    chk("t1_wait_done", busy, 32'h1);
    tx_busy = 1'b0;
    @(negedge clk); chk("t1_gap1", busy, 32'h1);
    @(negedge clk); chk("t1_gap2", busy, 32'h1);
    @(negedge clk); chk("t1_idle", busy, 32'h0);
    chk("t1_no_err", err, 32'h0);

    // All four requesting from reset: round robin 0,1,2,3
    do_reset();
    snap();
    data = 32'h3332_3130; req = 4'hF;
    for (int k = 0; k < 4; k++) begin
      wait_start(20);
      chk("t2_grant", grant, k);
      chk("t2_data", tx_data, 32'h30 + k);
      req = req & ~ack;
      serve(2, 3);
    end
    repeat (4) @(negedge clk);
    for (int i = 0; i < 4; i++) chk("t2_ack_count", ack_cnt[i] - base[i], 32'd1);
    chk("t2_idle", busy, 32'h0);

    // Fairness: 0 and 2 hold requests permanently
    snap();
    data = 32'h00A2_00A0; req = 4'b0101;
    for (int k = 0; k < 6; k++) begin
      wait_start(20);
      chk("t3_grant", grant, (k % 2 == 0) ? 0 : 2);
      chk("t3_data", tx_data, (k % 2 == 0) ? 32'hA0 : 32'hA2);
      if (k == 5) req = '0;
      serve(2, 3);
    end
    repeat (4) @(negedge clk);
    chk("t3_ack0", ack_cnt[0] - base[0], 32'd3);
    chk("t3_ack1", ack_cnt[1] - base[1], 32'd0);
    chk("t3_ack2", ack_cnt[2] - base[2], 32'd3);

    // Timeout: transmitter never raises busy
    data = 32'h0000_5500; req = 4'b0010;
    wait_start(20);
    chk("t4_grant", grant, 32'h1);
    req = '0;
    early = 1'b0;
    repeat (15) begin
      @(negedge clk);
      early = early | err;
    end
    chk("t4_no_early_err", early, 32'h0);
    @(negedge clk);
    chk("t4_err", err, 32'h1);
    chk("t4_idle", busy, 32'h0);
    @(negedge clk);
    chk("t4_err_pulse", err, 32'h0);
    data = 32'h7700_0000; req = 4'b1000;
    wait_start(5);
    chk("t4_next_grant", grant, 32'h3);
    chk("t4_next_data", tx_data, 32'h77);
    req = '0;
    serve(2, 3);
    repeat (4) @(negedge clk);

    // Busy blocks granting in IDLE
    tx_busy = 1'b1; data = 32'h0000_0011; req = 4'b0001;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen = seen | tx_start;
    end
    chk("t5_blocked", seen, 32'h0);
    chk("t5_idle", busy, 32'h0);
    tx_busy = 1'b0;
    @(negedge clk);
    chk("t5_start", tx_start, 32'h1);
    chk("t5_grant", grant, 32'h0);
    req = '0;
    // Busy arrives exactly on the edge where the counter reaches T-1
    repeat (15) @(negedge clk);
    tx_busy = 1'b1;
    @(negedge clk);
    chk("t5_edge_no_err", err, 32'h0);
    chk("t5_edge_busy", busy, 32'h1);
    @(negedge clk);
    chk("t5_edge_no_err2", err, 32'h0);
    tx_busy = 1'b0;
    repeat (4) @(negedge clk);
    chk("t5_done", busy, 32'h0);

    // Reset in WAIT_DONE
    data = 32'h0000_0022; req = 4'b0001;
    wait_start(5);
    req = '0;
    @(negedge clk);
    tx_busy = 1'b1;
    repeat (2) @(negedge clk);
    chk("t6_pre_busy", busy, 32'h1);
    chk("t6_pre_data", tx_data, 32'h22);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", busy, 32'h0);
    chk("t6_rst_data", tx_data, 32'h0);
    chk("t6_rst_start", tx_start, 32'h0);
    chk("t6_rst_ack", ack, 32'h0);
    chk("t6_rst_err", err, 32'h0);
    tx_busy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    data = 32'hD300_00D0; req = 4'b1001;
    @(negedge clk);
    chk("t6_start", tx_start, 32'h1);
    chk("t6_grant0", grant, 32'h0);
    chk("t6_data0", tx_data, 32'hD0);
    req = req & ~ack;
    serve(2, 3);
    wait_start(20);
    chk("t6_grant3", grant, 32'h3);
    chk("t6_data3", tx_data, 32'hD3);
    req = '0;
    serve(2, 3);
    repeat (4) @(negedge clk);

    // Back-to-back instance: next grant one IDLE cycle after busy falls
    data_z = 32'h0000_BBAA; req_z = 4'b0011;
    @(negedge clk);
    chk("z_start0", tx_start_z, 32'h1);
    chk("z_grant0", grant_z, 32'h0);
    chk("z_data0", tx_data_z, 32'hAA);
    req_z = 4'b0010; tx_busy_z = 1'b1;
    repeat (2) @(negedge clk);
    chk("z_wait_done", busy_z, 32'h1);
    tx_busy_z = 1'b0;
    @(negedge clk);
    chk("z_idle_busy", busy_z, 32'h0);
    chk("z_idle_start", tx_start_z, 32'h0);
    @(negedge clk);
    chk("z_start1", tx_start_z, 32'h1);
    chk("z_grant1", grant_z, 32'h1);
    chk("z_ack1", ack_z, 32'h2);
    chk("z_data1", tx_data_z, 32'hBB);
    req_z = '0; tx_busy_z = 1'b1;
    repeat (2) @(negedge clk);
    tx_busy_z = 1'b0;
    repeat (2) @(negedge clk);
    chk("z_done", busy_z, 32'h0);
    chk("z_no_err", err_z, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
